sseg_scan_decoder: RTL and testbench
====================================

Name: sseg_scan_decoder

Overview:
Passive monitor that reads a time-multiplexed, active-low 4-digit seven-segment bus (anodes AN0-AN3, cathodes CA-CG, DP) and reconstructs the displayed 16-bit hex value. It serves as on-board loopback and checker for display-driver FSMs. It ignores inter-digit bleeding and transients with a settle filter, and publishes one complete frame once all four digits have been seen.

Parameters:
SETTLE_CYCLES, 16, consecutive identical samples required before a bus pattern is accepted (min 2)
TIMEOUT_CYCLES, 1000000, cycles without any accepted capture before o_r_stale asserts
CNT_W, 32, width of the settle and timeout counters

Ports:
i_w_clk  in  1  single clock
i_w_reset  in  1  asynchronous, active-low reset
i_w_an  in  4  anode lines, active low; bit n is digit n
i_w_seg  in  7  cathodes {CG,CF,CE,CD,CC,CB,CA}, active low
i_w_dp  in  1  decimal point, active low
i_w_clr  in  1  synchronous clear of sticky error flags
o_r_value  out  16  last complete frame; digit n at bits [4n+3:4n]
o_r_dp  out  4  DP state per digit of the last frame, 1 = lit
o_r_frame_valid  out  1  one-cycle pulse when o_r_value/o_r_dp update
o_r_err_multi  out  1  sticky: a settled pattern had more than one anode low
o_r_err_pattern  out  1  sticky: a settled single-anode pattern was not a hex glyph
o_r_stale  out  1  high while no capture has occurred for TIMEOUT_CYCLES

Behaviour:
- Reset (asynchronous, i_w_reset=0): all outputs 0; digit registers, seen mask, counters and synchronizers 0; state S_SETTLE.
- Input path: {an, seg, dp} (12 bits) pass through a 2-flop synchronizer giving s. s_prev is s delayed one cycle.
- FSM, 2 states:
  - S_SETTLE: if s!=s_prev, cnt<=0. Else cnt<=cnt+1. When s==s_prev and cnt==SETTLE_CYCLES-2, evaluate s this cycle and go to S_HELD.
  - S_HELD: hold, no evaluation. On s!=s_prev, cnt<=0 and go to S_SETTLE.
  - Result: each stable dwell is evaluated exactly once. A dwell shorter than SETTLE_CYCLES is never evaluated.
- Evaluation of s:
  - All anodes high: blank. No action, no error.
  - More than one anode low: set o_r_err_multi. Nothing is captured.
  - Exactly one anode low (index n): decode seg.
    - Valid glyph: digit[n] <= nibble, dp[n] <= ~dp_line, seen[n] <= 1.
    - Invalid glyph: set o_r_err_pattern. digit[n] and seen are unchanged.
- Glyph table, active low {G..A}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is invalid.
- Frame publish:
  - Fires when a valid capture makes (seen | 1<<n) == 4'b1111.
  - Next edge: o_r_value <= all digits including the new nibble; o_r_dp likewise; o_r_frame_valid=1 for one cycle; seen <= 0.
  - Re-capturing an already-seen digit overwrites it without publishing.
- Latency: a bus change becomes stable at the pins at cycle t. The final digit's frame_valid is high at cycle t+2+SETTLE_CYCLES (2 synchronizer + settle).
- Timeout: tcnt is cleared on every valid capture and otherwise increments, saturating. o_r_stale = (tcnt >= TIMEOUT_CYCLES), registered. It clears the cycle after the next valid capture.
- Sticky errors:
  - Cleared by i_w_clr=1.
  - If i_w_clr and a new error occur in the same cycle, the set wins.
  - i_w_clr does not affect value, seen or counters.
- Reset mid-frame discards the partial seen mask. The next frame needs all four digits again.

Decomposition:
- Package sseg_pkg: the 16 active-low glyph constants, state encoding (S_SETTLE, S_HELD), digit count (4).
- Sub-module sseg_glyph_decode: combinational 7-bit pattern -> {valid, nibble[3:0]}. It is reusable by other display blocks and benches.

Test Plan:
- Frame capture: after reset, scan digits 0..3 showing 1,2,3,4 with DP off and 100-cycle dwells -> one frame_valid pulse, o_r_value=16'h4321, o_r_dp=4'b0000, no errors.
- Bleed filter: between dwells, insert a 5-cycle pattern AN=4'b1110, seg=glyph 8 (SETTLE_CYCLES=16) -> digit 0 not overwritten, value still 16'h4321 next frame, no errors.
- Multi-anode error: AN=4'b1100 stable for 50 cycles -> o_r_err_multi=1, no capture, no frame. Then i_w_clr=1 for one cycle -> flag 0.
- Bad glyph: AN=4'b1101, seg=7'b0111111 (dash) for 50 cycles -> o_r_err_pattern=1, seen[1] stays 0. A frame publishes only after digit 1 shows a valid glyph.
- Timeout: TIMEOUT_CYCLES=200, all anodes high for 300 cycles -> o_r_stale=1 from about cycle 200. A valid capture then drops stale one cycle later.
- Reset mid-frame: capture digits 0-2 (A,b,C), assert reset, release, scan full frame F,E,d,C -> o_r_value=16'hCdEF becomes 16'hCDEF, exactly one frame_valid pulse, no stale partial data.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan monitor: glyph patterns,
// FSM encoding and digit count.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_HELD   = 1'b1
  } state_t;

  // Active-low cathode patterns, bit order {G,F,E,D,C,B,A}
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational decode of an active-low seven-segment pattern into a hex nibble.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] i_w_seg,
  output logic       o_w_valid,
  output logic [3:0] o_w_nibble
);

  always_comb begin
    o_w_valid  = 1'b1;
    o_w_nibble = 4'h0;
    case (i_w_seg)
      GLYPH_0: o_w_nibble = 4'h0;
      GLYPH_1: o_w_nibble = 4'h1;
      GLYPH_2: o_w_nibble = 4'h2;
      GLYPH_3: o_w_nibble = 4'h3;
      GLYPH_4: o_w_nibble = 4'h4;
      GLYPH_5: o_w_nibble = 4'h5;
      GLYPH_6: o_w_nibble = 4'h6;
      GLYPH_7: o_w_nibble = 4'h7;
      GLYPH_8: o_w_nibble = 4'h8;
      GLYPH_9: o_w_nibble = 4'h9;
      GLYPH_A: o_w_nibble = 4'hA;
      GLYPH_B: o_w_nibble = 4'hB;
      GLYPH_C: o_w_nibble = 4'hC;
      GLYPH_D: o_w_nibble = 4'hD;
      GLYPH_E: o_w_nibble = 4'hE;
      GLYPH_F: o_w_nibble = 4'hF;
      default: o_w_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Passive monitor of a multiplexed active-low 4-digit seven-segment bus;
// rebuilds the shown 16-bit hex value once every digit has been seen.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input  logic        i_w_clk,
  input  logic        i_w_reset,
  input  logic [3:0]  i_w_an,
  input  logic [6:0]  i_w_seg,
  input  logic        i_w_dp,
  input  logic        i_w_clr,
  output logic [15:0] o_r_value,
  output logic [3:0]  o_r_dp,
  output logic        o_r_frame_valid,
  output logic        o_r_err_multi,
  output logic        o_r_err_pattern,
  output logic        o_r_stale
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [11:0]      r_sync_p0, r_sync_p1, r_prev_p2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_tcnt;
  logic             w_eval;
  logic             w_change;

  logic [3:0]       w_an_low;
  logic [6:0]       w_seg;
  logic             w_dp_lit;
  logic             w_glyph_valid;
  logic [3:0]       w_nibble;
  logic             w_single;
  logic             w_multi;
  logic             w_capture;
  logic             w_set_multi;
  logic             w_set_pattern;
  logic             w_frame_done;

  logic [15:0]      r_digits, w_digits_nxt;
  logic [3:0]       r_dps, w_dps_nxt;
  logic [3:0]       r_seen, w_seen_nxt;

  // Stage p0/p1: two-flop synchronizer; p2: previous synchronized sample
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_prev_p2 <= '0;
    end else begin
      r_sync_p0 <= {i_w_an, i_w_seg, i_w_dp};
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  assign w_change = (r_sync_p1 != r_prev_p2);

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_state <= S_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // One evaluation per stable dwell: S_HELD blocks re-evaluation until the bus moves
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_eval      = 1'b0;
    case (r_state)
      S_SETTLE: begin
        if (w_change) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == SETTLE_LAST) begin
            w_eval      = 1'b1;
            w_state_nxt = S_HELD;
          end
        end
      end
      S_HELD: begin
        if (w_change) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_SETTLE;
    endcase
  end

  assign w_an_low = ~r_sync_p1[11:8];
  assign w_seg    = r_sync_p1[7:1];
  assign w_dp_lit = ~r_sync_p1[0];

  sseg_glyph_decode u_glyph (
    .i_w_seg    (w_seg),
    .o_w_valid  (w_glyph_valid),
    .o_w_nibble (w_nibble)
  );

  assign w_single      = $onehot(w_an_low);
  assign w_multi       = (w_an_low != 4'b0000) && !w_single;
  assign w_capture     = w_eval && w_single && w_glyph_valid;
  assign w_set_multi   = w_eval && w_multi;
  assign w_set_pattern = w_eval && w_single && !w_glyph_valid;
  assign w_seen_nxt    = r_seen | w_an_low;
  assign w_frame_done  = w_capture && (w_seen_nxt == 4'b1111);

  always_comb begin
    w_digits_nxt = r_digits;
    w_dps_nxt    = r_dps;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_low[i]) begin
        w_digits_nxt[4*i +: 4] = w_nibble;
        w_dps_nxt[i]           = w_dp_lit;
      end
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_digits        <= '0;
      r_dps           <= '0;
      r_seen          <= '0;
      o_r_value       <= '0;
      o_r_dp          <= '0;
      o_r_frame_valid <= 1'b0;
    end else begin
      o_r_frame_valid <= w_frame_done;
      if (w_capture) begin
        r_digits <= w_digits_nxt;
        r_dps    <= w_dps_nxt;
        if (w_frame_done) begin
          r_seen    <= '0;
          o_r_value <= w_digits_nxt;
          o_r_dp    <= w_dps_nxt;
        end else begin
          r_seen    <= w_seen_nxt;
        end
      end
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      r_tcnt    <= '0;
      o_r_stale <= 1'b0;
    end else begin
      o_r_stale <= (r_tcnt >= TIMEOUT_LIM);
      if (w_capture) begin
        r_tcnt <= '0;
      end else if (r_tcnt != CNT_MAX) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  // A new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      o_r_err_multi   <= 1'b0;
      o_r_err_pattern <= 1'b0;
    end else begin
      if (w_set_multi) begin
        o_r_err_multi <= 1'b1;
      end else if (i_w_clr) begin
        o_r_err_multi <= 1'b0;
      end
      if (w_set_pattern) begin
        o_r_err_pattern <= 1'b1;
      end else if (i_w_clr) begin
        o_r_err_pattern <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: run-length bus model checked every cycle,
// plus directed scans with hand-computed results.
module tb_sseg_scan_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        dp = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] o_value;
  logic [3:0]  o_dp;
  logic        o_fv, o_emulti, o_epat, o_stale;

  int errors = 0;
  int checks = 0;
  int fcount = 0;
  bit mon_en = 1'b0;

  logic [6:0] GL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  sseg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (32)
  ) dut (
    .i_w_clk         (clk),
    .i_w_reset       (rst_n),
    .i_w_an          (an),
    .i_w_seg         (seg),
    .i_w_dp          (dp),
    .i_w_clr         (clr),
    .o_r_value       (o_value),
    .o_r_dp          (o_dp),
    .o_r_frame_valid (o_fv),
    .o_r_err_multi   (o_emulti),
    .o_r_err_pattern (o_epat),
    .o_r_stale       (o_stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: the bus seen two edges late; a pattern is judged when its run reaches SETTLE
  logic [11:0] m_p0, m_s;
  int          m_run, m_tcnt;
  logic [15:0] m_dig, m_value;
  logic [3:0]  m_dpv, m_dp, m_seen;
  logic        m_fv, m_emulti, m_epat, m_stale;

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] an_low;
    int nlow, idx, gi;
    bit cap, setm, setp;
    if (!rst_n) begin
      m_p0 = '0; m_s = '0; m_run = 2; m_tcnt = 0;
      m_dig = '0; m_value = '0; m_dpv = '0; m_dp = '0; m_seen = '0;
      m_fv = 0; m_emulti = 0; m_epat = 0; m_stale = 0;
    end else begin
      cap = 0; setm = 0; setp = 0; m_fv = 0;
      if (m_run == SETTLE) begin
        an_low = ~m_s[11:8];
        nlow = $countones(an_low);
        if (nlow > 1) setm = 1;
        else if (nlow == 1) begin
          idx = 0; gi = -1;
          for (int i = 0; i < 4; i++) if (an_low[i]) idx = i;
          for (int g = 0; g < 16; g++) if (GL[g] == m_s[7:1]) gi = g;
          if (gi < 0) setp = 1;
          else begin
            cap = 1;
            m_dig[4*idx +: 4] = gi[3:0];
            m_dpv[idx] = ~m_s[0];
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
              m_value = m_dig; m_dp = m_dpv; m_fv = 1; m_seen = '0;
            end
          end
        end
      end
      m_stale = (m_tcnt >= TIMEOUT);
      m_tcnt = cap ? 0 : m_tcnt + 1;
      if (setm) m_emulti = 1; else if (clr) m_emulti = 0;
      if (setp) m_epat = 1; else if (clr) m_epat = 0;
      if (m_p0 == m_s) m_run++; else m_run = 1;
      m_s = m_p0;
      m_p0 = {an, seg, dp};
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("value", 32'(o_value), 32'(m_value));
      chk("dp", 32'(o_dp), 32'(m_dp));
      chk("frame_valid", 32'(o_fv), 32'(m_fv));
      chk("err_multi", 32'(o_emulti), 32'(m_emulti));
      chk("err_pattern", 32'(o_epat), 32'(m_epat));
      chk("stale", 32'(o_stale), 32'(m_stale));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && o_fv) fcount++;
  end

  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int n, input int val, input bit lit, input int cyc);
    show(~(4'(1) << n), GL[val], ~lit, cyc);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int f0, lat;
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(o_value), 32'h0);
    chk("rst_flags", 32'({o_dp, o_fv, o_emulti, o_epat, o_stale}), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Frame capture 1,2,3,4 with final-digit latency measured
    f0 = fcount;
    dig(0, 1, 0, 100);
    dig(1, 2, 0, 100);
    dig(2, 3, 0, 100);
    an = 4'b0111; seg = GL[4]; dp = 1'b1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (o_fv && lat == 0) lat = k;
    end
    chk("latency", 32'(lat), 32'(SETTLE + 2));
    chk("frame1_value", 32'(o_value), 32'h4321);
    chk("frame1_dp", 32'(o_dp), 32'h0);
    chk("frame1_count", 32'(fcount - f0), 32'd1);
    chk("frame1_errs", 32'({o_emulti, o_epat}), 32'h0);

    // Bleed glitches of glyph 8 on digit 0 between dwells; DP lit on digit 2
    f0 = fcount;
    dig(0, 1, 0, 100); show(4'b1110, GL[8], 1'b1, 5);
    dig(1, 2, 0, 100); show(4'b1110, GL[8], 1'b1, 5);
    dig(2, 3, 1, 100); show(4'b1110, GL[8], 1'b1, 5);
    dig(3, 4, 0, 100);
    chk("bleed_value", 32'(o_value), 32'h4321);
    chk("bleed_dp", 32'(o_dp), 32'h4);
    chk("bleed_count", 32'(fcount - f0), 32'd1);
    chk("bleed_errs", 32'({o_emulti, o_epat}), 32'h0);

    // Multi-anode error, clear, then clear held across a new error
    f0 = fcount;
    show(4'b1100, GL[1], 1'b1, 50);
    chk("multi_set", 32'(o_emulti), 32'h1);
    show(4'hF, 7'h7F, 1'b1, 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("multi_clr", 32'(o_emulti), 32'h0);
    clr = 1'b1;
    show(4'b0101, GL[2], 1'b1, 50);
    clr = 1'b0;
    chk("multi_after_clr", 32'(o_emulti), 32'h0);
    chk("multi_nocap", 32'(fcount - f0), 32'd0);

    // Bad glyph on digit 1 holds back the frame until a valid glyph arrives
    f0 = fcount;
    dig(0, 5, 0, 30);
    show(4'b1101, 7'b0111111, 1'b1, 50);
    chk("pattern_set", 32'(o_epat), 32'h1);
    dig(2, 7, 0, 30);
    dig(3, 8, 0, 30);
    chk("pattern_noframe", 32'(fcount - f0), 32'd0);
    dig(1, 9, 0, 30);
    chk("pattern_frame", 32'(fcount - f0), 32'd1);
    chk("pattern_value", 32'(o_value), 32'h8795);

    // Timeout with blank bus, then a capture drops stale
    show(4'hF, 7'h7F, 1'b1, 300);
    chk("stale_set", 32'(o_stale), 32'h1);
    dig(0, 3, 0, 30);
    chk("stale_clr", 32'(o_stale), 32'h0);

    // Reset mid-frame discards partial digits
    dig(0, 10, 0, 30);
    dig(1, 11, 0, 30);
    dig(2, 12, 0, 30);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_value", 32'(o_value), 32'h0);
    chk("midrst_flags", 32'({o_dp, o_emulti, o_epat, o_stale}), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    f0 = fcount;
    dig(0, 15, 0, 30);
    dig(1, 14, 0, 30);
    dig(2, 13, 0, 30);
    dig(3, 12, 0, 30);
    chk("midrst_frame", 32'(o_value), 32'hCDEF);
    chk("midrst_count", 32'(fcount - f0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
